// File: rtl/acc_sched_pkg.sv
// ============================================================================
// acc_sched_pkg : shared types and default widths for the accumulator scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package acc_sched_pkg;

   localparam int DEF_W  = 4;
   localparam int DEF_CW = 3;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_INC  = 2'b01,
      OP_CLR  = 2'b10,
      OP_READ = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

endpackage

`default_nettype wire

// File: rtl/acc_core.sv
// ============================================================================
// acc_core : W-bit accumulator register, priority clear > add > increment > hold
// Rev 1.0
// ============================================================================
`default_nettype none

module acc_core
   import acc_sched_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         add_en,
   input  logic [W-1:0] operand,
   input  logic         inc_en,
   output logic [W-1:0] q
);

   logic [W-1:0] acc_q;
   logic [W-1:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (add_en) begin
         acc_d = acc_q + operand;
      end else if (inc_en) begin
         acc_d = acc_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign q = acc_q;

endmodule

`default_nettype wire

// File: rtl/acc_scheduler.sv
// ============================================================================
// acc_scheduler : round-robin sharing of one accumulator between two requesters
// Rev 1.0
// ============================================================================
`default_nettype none

module acc_scheduler
   import acc_sched_pkg::*;
#(
   parameter int W  = DEF_W,
   parameter int CW = DEF_CW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [1:0][1:0]      req_op,
   input  logic [1:0][W-1:0]    req_operand,
   input  logic [1:0][CW-1:0]   req_count,
   output logic                 rsp_valid,
   output logic                 rsp_id,
   output logic [W-1:0]         rsp_acc,
   output logic [W-1:0]         acc_out,
   output logic                 busy
);

   state_t         state_q,   state_d;
   op_t            op_q,      op_d;
   logic [W-1:0]   operand_q, operand_d;
   logic [CW-1:0]  cnt_q,     cnt_d;
   logic           id_q,      id_d;
   logic           last_q,    last_d;
   logic           rsp_id_q,  rsp_id_d;
   logic [W-1:0]   rsp_acc_q, rsp_acc_d;

   logic           grant_id;
   op_t            grant_op;
   logic           clr;
   logic           add_en;
   logic           inc_en;
   logic [W-1:0]   acc_q;

   // last_q is the most recently granted index; contention goes to the other one
   assign grant_id = (&req_valid) ? ~last_q : req_valid[1];
   assign grant_op = op_t'(req_op[grant_id]);

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      operand_d = operand_q;
      cnt_d     = cnt_q;
      id_d      = id_q;
      last_d    = last_q;
      rsp_id_d  = rsp_id_q;
      rsp_acc_d = rsp_acc_q;
      req_ready = 2'b00;
      clr       = 1'b0;
      add_en    = 1'b0;
      inc_en    = 1'b0;
      rsp_valid = 1'b0;
      rsp_id    = rsp_id_q;
      rsp_acc   = rsp_acc_q;

      case (state_q)
         S_IDLE: begin
            if (|req_valid) begin
               req_ready = grant_id ? 2'b10 : 2'b01;
               op_d      = grant_op;
               operand_d = req_operand[grant_id];
               cnt_d     = (grant_op inside {OP_ADD, OP_INC}) ? req_count[grant_id] : '0;
               id_d      = grant_id;
               last_d    = grant_id;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            case (op_q)
               OP_ADD:  add_en = 1'b1;
               OP_INC:  inc_en = 1'b1;
               OP_CLR:  clr    = 1'b1;
               default: ;
            endcase
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            rsp_valid = 1'b1;
            rsp_id    = id_q;
            rsp_acc   = acc_q;
            rsp_id_d  = id_q;
            rsp_acc_d = acc_q;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // last_q resets to 1 so that requester 0 wins the first contention
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= OP_ADD;
         operand_q <= '0;
         cnt_q     <= '0;
         id_q      <= 1'b0;
         last_q    <= 1'b1;
         rsp_id_q  <= 1'b0;
         rsp_acc_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         operand_q <= operand_d;
         cnt_q     <= cnt_d;
         id_q      <= id_d;
         last_q    <= last_d;
         rsp_id_q  <= rsp_id_d;
         rsp_acc_q <= rsp_acc_d;
      end
   end

   acc_core #(
      .W (W)
   ) u_acc_core (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .add_en  (add_en),
      .operand (operand_q),
      .inc_en  (inc_en),
      .q       (acc_q)
   );

   assign acc_out = acc_q;
   assign busy    = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_acc_scheduler.sv
// ============================================================================
// tb_acc_scheduler : scoreboard bench for acc_scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_acc_scheduler;

   localparam int W  = 4;
   localparam int CW = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [1:0][1:0]     req_op;
   logic [1:0][W-1:0]   req_operand;
   logic [1:0][CW-1:0]  req_count;
   logic                rsp_valid;
   logic                rsp_id;
   logic [W-1:0]        rsp_acc;
   logic [W-1:0]        acc_out;
   logic                busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic          id;
      logic [W-1:0]  acc;
      int            cyc;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   logic [W-1:0]  m_acc;
   logic          last_id;
   logic [W-1:0]  last_acc;

   acc_scheduler #(
      .W  (W),
      .CW (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_operand (req_operand),
      .req_count   (req_count),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_acc     (rsp_acc),
      .acc_out     (acc_out),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: advance m_acc and queue the expected response
   task automatic push_exp(input int id, input logic [1:0] op, input logic [W-1:0] opnd,
                           input logic [CW-1:0] cnt);
      exp_t e;
      case (op)
         2'b00: for (int i = 0; i <= int'(cnt); i++) m_acc = m_acc + opnd;
         2'b01: for (int i = 0; i <= int'(cnt); i++) m_acc = m_acc + 1'b1;
         2'b10: m_acc = '0;
         default: ;
      endcase
      e.id  = id[0];
      e.acc = m_acc;
      e.cyc = cyc + 2 + ((op == 2'b00 || op == 2'b01) ? int'(cnt) : 0);
      sb.push_back(e);
   endtask

   task automatic issue(input int id, input logic [1:0] op, input logic [W-1:0] opnd,
                        input logic [CW-1:0] cnt);
      int n;
      req_op[id]      = op;
      req_operand[id] = opnd;
      req_count[id]   = cnt;
      req_valid[id]   = 1'b1;
      #1;
      n = 0;
      while (!req_ready[id] && n < 50) begin
         step();
         n++;
      end
      check_val("grant_wait", 32'(n < 50), 1);
      push_exp(id, op, opnd, cnt);
      step();
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 30) begin
         step();
         n++;
      end
      check_val("idle_wait", 32'(n < 30), 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      m_acc = '0;
      sb.delete();
   endtask

   always @(negedge clk) begin
      if (rst) begin
         last_id  <= 1'b0;
         last_acc <= '0;
      end else begin
         check_val("ready_onehot", 32'(req_ready != 2'b11), 1);
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               check_val("rsp_unexpected", 32'(rsp_valid), 0);
            end else begin
               mon_e = sb.pop_front();
               check_val("rsp_id", 32'(rsp_id), 32'(mon_e.id));
               check_val("rsp_acc", 32'(rsp_acc), 32'(mon_e.acc));
               check_val("rsp_cycle", cyc, mon_e.cyc);
            end
            last_id  <= rsp_id;
            last_acc <= rsp_acc;
         end else begin
            check_val("rsp_id_hold", 32'(rsp_id), 32'(last_id));
            check_val("rsp_acc_hold", 32'(rsp_acc), 32'(last_acc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int g;
      rst         = 1'b1;
      req_valid   = '0;
      req_op      = '0;
      req_operand = '0;
      req_count   = '0;
      m_acc       = '0;
      step();
      rst = 1'b0;
      #1;
      check_val("rst_acc", 32'(acc_out), 0);
      check_val("rst_busy", 32'(busy), 0);
      check_val("rst_rsp_valid", 32'(rsp_valid), 0);
      check_val("rst_rsp_acc", 32'(rsp_acc), 0);
      check_val("rst_ready", 32'(req_ready), 0);

      // 1: ADD 3 x3 from requester 0
      issue(0, 2'b00, 4'd3, 3'd2);
      check_val("t1_acc0", 32'(acc_out), 0);
      check_val("t1_busy", 32'(busy), 1);
      step();
      check_val("t1_acc1", 32'(acc_out), 3);
      step();
      check_val("t1_acc2", 32'(acc_out), 6);
      step();
      check_val("t1_acc3", 32'(acc_out), 9);
      check_val("t1_rsp_valid", 32'(rsp_valid), 1);
      wait_idle(n);

      // 2: bring acc to 12, then 8 increments wrap to 4
      issue(1, 2'b00, 4'd3, 3'd0);
      wait_idle(n);
      check_val("t2_acc12", 32'(acc_out), 12);
      issue(1, 2'b01, 4'd0, 3'd7);
      wait_idle(n);
      check_val("t2_busy_cycles", n, 9);
      check_val("t2_acc", 32'(acc_out), 4);

      // 3: both requesters READ continuously, grants must alternate
      do_reset();
      req_op      = {2'b11, 2'b11};
      req_valid   = 2'b11;
      for (g = 0; g < 4; g++) begin
         #1;
         n = 0;
         while (req_ready == 2'b00 && n < 50) begin
            step();
            n++;
         end
         check_val("t3_grant", 32'(req_ready), (g % 2 == 1) ? 2 : 1);
         push_exp(req_ready[1] ? 1 : 0, 2'b11, '0, '0);
         step();
         if (g == 3) req_valid = 2'b00;
         wait_idle(n);
      end

      // 4: reset during a long ADD discards it
      issue(0, 2'b00, 4'd1, 3'd7);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      m_acc = '0;
      sb.delete();
      check_val("t4_acc", 32'(acc_out), 0);
      check_val("t4_busy", 32'(busy), 0);
      step();
      step();
      issue(1, 2'b00, 4'd5, 3'd0);
      wait_idle(n);
      check_val("t4_acc5", 32'(acc_out), 5);

      // 5: CLR ignores its count, then READ
      issue(0, 2'b10, 4'd7, 3'd5);
      wait_idle(n);
      issue(0, 2'b11, 4'd0, 3'd0);
      wait_idle(n);

      // 6: from 1, ADD 15 once wraps to 0
      issue(1, 2'b01, 4'd0, 3'd0);
      wait_idle(n);
      issue(1, 2'b00, 4'd15, 3'd0);
      wait_idle(n);
      check_val("t6_acc", 32'(acc_out), 0);

      step();
      step();
      check_val("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/acc_scheduler.md
Name: acc_scheduler

Overview:
- Shares one W-bit accumulator between two requesters and sequences its add/increment controls.
- Each requester submits an operation over a valid/ready handshake. Round-robin arbitration picks one request at a time.
- The scheduler drives the accumulator's add-operand and increment selects for the required number of cycles, then returns the result on a one-cycle response strobe.
- Sits between requester logic and the accumulator datapath; contains the accumulator as a sub-module.

Parameters:
W, 4, accumulator and operand width
CW, 3, repeat-count width (an operation executes count+1 steps)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  2  request valid, bit i = requester i
req_ready  output  2  one-hot grant/accept, at most one bit high
req_op  input  2x2  op per requester: 00 ADD, 01 INC, 10 CLR, 11 READ
req_operand  input  2xW  addend per requester (ADD only)
req_count  input  2xCW  repeat count per requester (ADD/INC only)
rsp_valid  output  1  one-cycle completion strobe
rsp_id  output  1  requester index of completed op
rsp_acc  output  W  accumulator value after the op
acc_out  output  W  live accumulator value
busy  output  1  high in RUN and DONE

Behaviour:
- The clock is clk. Reset is synchronous and active-high on rst; it is sampled only at the clk rising edge.
- Reset values:
  - state IDLE, accumulator 0, round-robin pointer favours requester 0.
  - rsp_valid 0, rsp_id 0, rsp_acc 0, busy 0, req_ready 00.
- State machine IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - If any req_valid is set, req_ready asserts combinationally for the granted requester in that cycle.
  - The granted op, operand and count are latched at the edge. Next state is RUN.
  - If no req_valid is set, the block stays in IDLE and req_ready is 00.
- Arbitration:
  - With a single valid requester, that requester is granted.
  - With both valid, the requester not granted last is chosen. The pointer updates only on a grant.
- RUN, per op:
  - ADD: asserts the add select for count+1 consecutive cycles; acc <= acc + operand each cycle.
  - INC: asserts the increment select for count+1 cycles; acc <= acc + 1 each cycle.
  - CLR: one RUN cycle; acc <= 0.
  - READ: one RUN cycle; acc holds.
  - A remaining-steps counter is loaded with count at accept and decrements each RUN cycle. The transition to DONE happens on the cycle the counter is 0.
- DONE:
  - rsp_valid=1 for exactly one cycle, with rsp_id = granted index and rsp_acc = accumulator value.
  - There is no response backpressure. Next state is IDLE.
  - rsp_id and rsp_acc hold their last values when rsp_valid=0.
- Latency:
  - Accept at cycle T. ADD/INC respond at T+2+count; CLR/READ respond at T+2.
  - The next accept is possible at T+3+count (T+3 for CLR/READ).
- Arithmetic: all sums truncate modulo 2^W, with no carry/overflow flag.
- Accumulator priority: clear > add > increment > hold. Only one select is driven per cycle.
- req_ready is 00 in RUN and DONE. New requests wait; requesters must hold valid and payload stable until ready.
- Reset mid-operation: at the next edge the block is in IDLE with acc=0. The in-flight op is discarded, no rsp_valid is produced, and the pointer returns to requester 0.
- acc_out always reflects the registered accumulator.

Decomposition:
- Package acc_sched_pkg holds:
  - op_t enum {OP_ADD, OP_INC, OP_CLR, OP_READ};
  - state_t enum {S_IDLE, S_RUN, S_DONE};
  - default widths W=4, CW=3.
- Sub-module acc_core: W-bit register with clk, synchronous active-high rst, clr, add_en, operand, inc_en, q. Same add/increment priority behaviour as the existing accumulator, but with synchronous reset and an added clear.
- acc_scheduler holds the FSM, round-robin pointer, latched request, step counter and response registers.

Test Plan:
1. rst 1 cycle; req0 ADD operand=3 count=2 -> req_ready=01 at T; acc 3,6,9 over T+1..T+3; rsp_valid at T+4 with rsp_id=0, rsp_acc=9.
2. From acc=12, req1 INC count=7 -> 8 increments; rsp_acc=4 (20 mod 16); rsp_id=1; busy high T+1..T+9.
3. Both req_valid held high after reset with READ ops -> grants in order 0,1,0,1; each rsp_acc unchanged; req_ready never 11.
4. req0 ADD operand=1 count=7, rst pulsed at T+3 -> next cycle acc=0, busy=0, no rsp_valid; a subsequent req1 grant works normally.
5. From acc=5, req0 CLR -> rsp_valid at T+2 with rsp_acc=0; then READ -> rsp_acc=0.
6. From acc=1, req1 ADD operand=15 count=0 -> single RUN cycle; rsp_acc=0 (wrap) at T+2.
